// File: rtl/ibex_pkg.sv
// Shared types and helpers for the custom-instruction issue stage.
package ibex_pkg;

  // Custom opcodes understood by the bloom-filter unit. Any other value is illegal.
  typedef enum logic [4:0] {
    CUST_RESET  = 5'd0,
    CUST_INSERT = 5'd1,
    CUST_CHECK  = 5'd2
  } custom_op_e;

  // Sequencing states of the issue stage.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } custom_issue_state_e;

  // The opcode is passed zero-extended to 32 bits so the helpers work for any
  // opcode field width up to 32.
  function automatic logic custom_op_is_legal(input logic [31:0] op);
    return op <= 32'(CUST_CHECK);
  endfunction

  // Only CHECK produces a value that belongs in the register file.
  function automatic logic custom_op_writes_rd(input logic [31:0] op);
    return op == 32'(CUST_CHECK);
  endfunction

endpackage

// File: rtl/ibex_custom_issue.sv
// Issue/sequencing stage between ID and the bloom-filter custom unit.
// Handshake semantics: ID transfers an instruction on a cycle where
// id_custom_req_i & id_custom_gnt_o; EX sees a single-cycle ex_custom_en_o
// and answers with ex_custom_valid_i (only honoured in ISSUE/WAIT);
// writeback transfers the result on a cycle where wb_valid_o & wb_ready_i.
module ibex_custom_issue
  import ibex_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 64,
  parameter int unsigned OpWidth       = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               id_custom_req_i,
  output logic               id_custom_gnt_o,
  input  logic [OpWidth-1:0] id_custom_op_i,
  input  logic [31:0]        id_rs1_i,
  input  logic [31:0]        id_rs2_i,
  input  logic [4:0]         id_rd_addr_i,
  input  logic               flush_i,
  output logic               ex_custom_en_o,
  output logic [OpWidth-1:0] ex_custom_op_o,
  output logic [31:0]        ex_rs1_o,
  output logic [31:0]        ex_rs2_o,
  input  logic               ex_custom_valid_i,
  input  logic [31:0]        ex_custom_result_i,
  output logic               wb_valid_o,
  input  logic               wb_ready_i,
  output logic               wb_we_o,
  output logic [4:0]         wb_rd_addr_o,
  output logic [31:0]        wb_result_o,
  output logic               wb_err_o,
  output logic               busy_o
);

  // One extra bit so the counter can never wrap before the timeout compare.
  localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;

  custom_issue_state_e r_state;
  logic [OpWidth-1:0]  r_op;
  logic [31:0]         r_rs1;
  logic [31:0]         r_rs2;
  logic [4:0]          r_rd;
  logic [31:0]         r_result;
  logic                r_err;
  logic [CntW-1:0]     r_cnt;
  logic                r_rst_q;

  logic w_live;
  logic w_gnt;
  logic w_accept;
  logic w_op_legal;

  // Outputs are forced low while reset is asserted; r_rst_q extends the
  // grant block into the first cycle after reset.
  assign w_live     = ~rst_i;
  assign w_gnt      = w_live & ~r_rst_q & ~flush_i & (r_state == IDLE);
  assign w_accept   = w_gnt & id_custom_req_i;
  assign w_op_legal = custom_op_is_legal(32'(id_custom_op_i));

  // Sequencer: accept from ID, pulse EX, wait for the unit or time out, hold for WB.
  always_ff @(posedge clk_i) begin
    r_rst_q <= rst_i;
    if (rst_i) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else if (flush_i) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op  <= id_custom_op_i;
            r_rs1 <= id_rs1_i;
            r_rs2 <= id_rs2_i;
            r_rd  <= id_rd_addr_i;
            r_cnt <= '0;
            if (w_op_legal) begin
              r_err   <= 1'b0;
              r_state <= ISSUE;
            end else begin
              // Illegal opcode bypasses EX entirely.
              r_err    <= 1'b1;
              r_result <= '0;
              r_state  <= DONE;
            end
          end
        end
        ISSUE: begin
          r_cnt <= '0;
          if (ex_custom_valid_i) begin
            r_result <= ex_custom_result_i;
            r_err    <= 1'b0;
            r_state  <= DONE;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (ex_custom_valid_i) begin
            r_result <= ex_custom_result_i;
            r_err    <= 1'b0;
            r_state  <= DONE;
          end else if (r_cnt == CntW'(TimeoutCycles - 1)) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (wb_ready_i) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign id_custom_gnt_o = w_gnt;
  assign ex_custom_en_o  = w_live & (r_state == ISSUE);
  assign ex_custom_op_o  = r_op & {OpWidth{w_live}};
  assign ex_rs1_o        = r_rs1 & {32{w_live}};
  assign ex_rs2_o        = r_rs2 & {32{w_live}};
  assign wb_valid_o      = w_live & (r_state == DONE);
  assign wb_we_o         = w_live & (r_state == DONE) & ~r_err &
                           custom_op_writes_rd(32'(r_op));
  assign wb_rd_addr_o    = r_rd & {5{w_live}};
  assign wb_result_o     = r_result & {32{w_live}};
  assign wb_err_o        = w_live & r_err;
  assign busy_o          = w_live & (r_state != IDLE);

endmodule

// File: tb/tb_ibex_custom_issue.sv
// Directed bench for the custom-instruction issue stage (TimeoutCycles = 4).
module tb_ibex_custom_issue;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_custom_req_i;
  logic        id_custom_gnt_o;
  logic [4:0]  id_custom_op_i;
  logic [31:0] id_rs1_i;
  logic [31:0] id_rs2_i;
  logic [4:0]  id_rd_addr_i;
  logic        flush_i;
  logic        ex_custom_en_o;
  logic [4:0]  ex_custom_op_o;
  logic [31:0] ex_rs1_o;
  logic [31:0] ex_rs2_o;
  logic        ex_custom_valid_i;
  logic [31:0] ex_custom_result_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic        wb_we_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_result_o;
  logic        wb_err_o;
  logic        busy_o;

  int n_vec = 0;
  int n_err = 0;

  // Clock.
  always #5 clk_i = ~clk_i;

  ibex_custom_issue #(
    .TimeoutCycles(4),
    .OpWidth      (5)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .id_custom_req_i   (id_custom_req_i),
    .id_custom_gnt_o   (id_custom_gnt_o),
    .id_custom_op_i    (id_custom_op_i),
    .id_rs1_i          (id_rs1_i),
    .id_rs2_i          (id_rs2_i),
    .id_rd_addr_i      (id_rd_addr_i),
    .flush_i           (flush_i),
    .ex_custom_en_o    (ex_custom_en_o),
    .ex_custom_op_o    (ex_custom_op_o),
    .ex_rs1_o          (ex_rs1_o),
    .ex_rs2_o          (ex_rs2_o),
    .ex_custom_valid_i (ex_custom_valid_i),
    .ex_custom_result_i(ex_custom_result_i),
    .wb_valid_o        (wb_valid_o),
    .wb_ready_i        (wb_ready_i),
    .wb_we_o           (wb_we_o),
    .wb_rd_addr_o      (wb_rd_addr_o),
    .wb_result_o       (wb_result_o),
    .wb_err_o          (wb_err_o),
    .busy_o            (busy_o)
  );

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},   32'(id_custom_gnt_o), 32'd0);
    chk({tag, "_en"},    32'(ex_custom_en_o),  32'd0);
    chk({tag, "_op"},    32'(ex_custom_op_o),  32'd0);
    chk({tag, "_rs1"},   ex_rs1_o,             32'd0);
    chk({tag, "_rs2"},   ex_rs2_o,             32'd0);
    chk({tag, "_wbv"},   32'(wb_valid_o),      32'd0);
    chk({tag, "_we"},    32'(wb_we_o),         32'd0);
    chk({tag, "_rd"},    32'(wb_rd_addr_o),    32'd0);
    chk({tag, "_res"},   wb_result_o,          32'd0);
    chk({tag, "_err"},   32'(wb_err_o),        32'd0);
    chk({tag, "_busy"},  32'(busy_o),          32'd0);
  endtask

  initial begin
    rst_i = 1'b1; id_custom_req_i = 1'b0; id_custom_op_i = '0;
    id_rs1_i = '0; id_rs2_i = '0; id_rd_addr_i = '0; flush_i = 1'b0;
    ex_custom_valid_i = 1'b0; ex_custom_result_i = '0; wb_ready_i = 1'b0;

    // ---- reset: outputs low during reset and the cycle after
    cyc(); #1;
    chk_all_zero("rst_on");
    cyc(); rst_i = 1'b0; #1;
    chk("rst_after_gnt", 32'(id_custom_gnt_o), 32'd0);
    chk("rst_after_busy", 32'(busy_o), 32'd0);
    cyc(); #1;
    chk("idle_gnt", 32'(id_custom_gnt_o), 32'd1);

    // ---- legal CHECK with 3-cycle unit latency and WB backpressure
    id_custom_req_i = 1'b1; id_custom_op_i = 5'd2; id_rs1_i = 32'hDEAD_BEEF;
    id_rs2_i = 32'h1; id_rd_addr_i = 5'd5; #1;
    chk("chk_gnt", 32'(id_custom_gnt_o), 32'd1);
    chk("chk_en_idle", 32'(ex_custom_en_o), 32'd0);
    cyc(); id_custom_req_i = 1'b0; id_rs1_i = 32'h0; #1;
    chk("chk_en", 32'(ex_custom_en_o), 32'd1);
    chk("chk_rs1", ex_rs1_o, 32'hDEAD_BEEF);
    chk("chk_rs2", ex_rs2_o, 32'h1);
    chk("chk_op", 32'(ex_custom_op_o), 32'd2);
    chk("chk_busy", 32'(busy_o), 32'd1);
    chk("chk_gnt_busy", 32'(id_custom_gnt_o), 32'd0);
    cyc(); #1;
    chk("chk_en_once", 32'(ex_custom_en_o), 32'd0);
    chk("chk_rs1_stable", ex_rs1_o, 32'hDEAD_BEEF);
    cyc(); #1;
    chk("chk_wait_wbv", 32'(wb_valid_o), 32'd0);
    cyc(); ex_custom_valid_i = 1'b1; ex_custom_result_i = 32'h1; #1;
    cyc(); ex_custom_valid_i = 1'b0; ex_custom_result_i = 32'h0; #1;
    chk("chk_wbv", 32'(wb_valid_o), 32'd1);
    chk("chk_we", 32'(wb_we_o), 32'd1);
    chk("chk_rd", 32'(wb_rd_addr_o), 32'd5);
    chk("chk_res", wb_result_o, 32'h1);
    chk("chk_err", 32'(wb_err_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("hold_wbv", 32'(wb_valid_o), 32'd1);
      chk("hold_we", 32'(wb_we_o), 32'd1);
      chk("hold_rd", 32'(wb_rd_addr_o), 32'd5);
      chk("hold_res", wb_result_o, 32'h1);
      chk("hold_gnt", 32'(id_custom_gnt_o), 32'd0);
    end
    wb_ready_i = 1'b1; #1;
    chk("done_no_gnt", 32'(id_custom_gnt_o), 32'd0);
    cyc(); wb_ready_i = 1'b0; #1;
    chk("back_idle_wbv", 32'(wb_valid_o), 32'd0);
    chk("back_idle_busy", 32'(busy_o), 32'd0);
    chk("back_idle_gnt", 32'(id_custom_gnt_o), 32'd1);

    // ---- INSERT, zero-wait unit, then a stray valid in IDLE
    id_custom_req_i = 1'b1; id_custom_op_i = 5'd1; id_rs1_i = 32'h0BAD_F00D;
    id_rd_addr_i = 5'd3; #1;
    chk("ins_gnt", 32'(id_custom_gnt_o), 32'd1);
    cyc(); id_custom_req_i = 1'b0; ex_custom_valid_i = 1'b1; ex_custom_result_i = 32'h1234; #1;
    chk("ins_en", 32'(ex_custom_en_o), 32'd1);
    cyc(); ex_custom_valid_i = 1'b0; ex_custom_result_i = 32'h0; #1;
    chk("ins_wbv", 32'(wb_valid_o), 32'd1);
    chk("ins_we", 32'(wb_we_o), 32'd0);
    chk("ins_err", 32'(wb_err_o), 32'd0);
    chk("ins_res", wb_result_o, 32'h1234);
    wb_ready_i = 1'b1;
    cyc(); wb_ready_i = 1'b0; ex_custom_valid_i = 1'b1; ex_custom_result_i = 32'hFFFF; #1;
    chk("stray_busy", 32'(busy_o), 32'd0);
    cyc(); ex_custom_valid_i = 1'b0; ex_custom_result_i = 32'h0; #1;
    chk("stray_busy2", 32'(busy_o), 32'd0);
    chk("stray_wbv", 32'(wb_valid_o), 32'd0);
    chk("stray_res", wb_result_o, 32'h1234);
    chk("stray_en", 32'(ex_custom_en_o), 32'd0);

    // ---- illegal opcode: straight to DONE, EX never enabled
    id_custom_req_i = 1'b1; id_custom_op_i = 5'd7; id_rs1_i = 32'h7777; id_rd_addr_i = 5'd9; #1;
    chk("ill_gnt", 32'(id_custom_gnt_o), 32'd1);
    cyc(); id_custom_req_i = 1'b0; #1;
    chk("ill_en", 32'(ex_custom_en_o), 32'd0);
    chk("ill_wbv", 32'(wb_valid_o), 32'd1);
    chk("ill_err", 32'(wb_err_o), 32'd1);
    chk("ill_res", wb_result_o, 32'h0);
    chk("ill_we", 32'(wb_we_o), 32'd0);
    chk("ill_rd", 32'(wb_rd_addr_o), 32'd9);
    wb_ready_i = 1'b1;
    cyc(); wb_ready_i = 1'b0; #1;
    chk("ill_idle", 32'(busy_o), 32'd0);

    // ---- timeout after 4 WAIT cycles, late valid ignored
    id_custom_req_i = 1'b1; id_custom_op_i = 5'd2; id_rs1_i = 32'h4444; id_rd_addr_i = 5'd4; #1;
    cyc(); id_custom_req_i = 1'b0; #1;
    chk("to_en", 32'(ex_custom_en_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      chk("to_wait_wbv", 32'(wb_valid_o), 32'd0);
      chk("to_wait_busy", 32'(busy_o), 32'd1);
      chk("to_wait_en", 32'(ex_custom_en_o), 32'd0);
    end
    cyc(); #1;
    chk("to_wbv", 32'(wb_valid_o), 32'd1);
    chk("to_err", 32'(wb_err_o), 32'd1);
    chk("to_res", wb_result_o, 32'h0);
    chk("to_we", 32'(wb_we_o), 32'd0);
    wb_ready_i = 1'b1;
    cyc(); wb_ready_i = 1'b0; ex_custom_valid_i = 1'b1; ex_custom_result_i = 32'h55; #1;
    cyc(); ex_custom_valid_i = 1'b0; ex_custom_result_i = 32'h0; #1;
    chk("late_res", wb_result_o, 32'h0);
    chk("late_busy", 32'(busy_o), 32'd0);

    // ---- flush in WAIT
    id_custom_req_i = 1'b1; id_custom_op_i = 5'd2; id_rs1_i = 32'hAAAA; id_rd_addr_i = 5'd6; #1;
    cyc(); id_custom_req_i = 1'b0; #1;
    cyc(); flush_i = 1'b1; #1;
    chk("fl_gnt", 32'(id_custom_gnt_o), 32'd0);
    cyc(); flush_i = 1'b0; #1;
    chk("fl_busy", 32'(busy_o), 32'd0);
    chk("fl_wbv", 32'(wb_valid_o), 32'd0);
    chk("fl_gnt_back", 32'(id_custom_gnt_o), 32'd1);

    // ---- flush with simultaneous request: nothing accepted
    id_custom_req_i = 1'b1; flush_i = 1'b1; id_custom_op_i = 5'd2; id_rs1_i = 32'h1234_5678; #1;
    chk("flreq_gnt", 32'(id_custom_gnt_o), 32'd0);
    cyc(); id_custom_req_i = 1'b0; flush_i = 1'b0; #1;
    chk("flreq_busy", 32'(busy_o), 32'd0);
    chk("flreq_en", 32'(ex_custom_en_o), 32'd0);
    chk("flreq_rs1", ex_rs1_o, 32'hAAAA);

    // ---- reset pulsed in DONE
    id_custom_req_i = 1'b1; id_custom_op_i = 5'd2; id_rs1_i = 32'h7070; id_rd_addr_i = 5'd7; #1;
    cyc(); id_custom_req_i = 1'b0; ex_custom_valid_i = 1'b1; ex_custom_result_i = 32'h77; #1;
    cyc(); ex_custom_valid_i = 1'b0; ex_custom_result_i = 32'h0; #1;
    chk("rd_done_wbv", 32'(wb_valid_o), 32'd1);
    rst_i = 1'b1; #1;
    chk("rd_rst_wbv", 32'(wb_valid_o), 32'd0);
    chk("rd_rst_gnt", 32'(id_custom_gnt_o), 32'd0);
    cyc(); rst_i = 1'b0; #1;
    chk_all_zero("rd_after");
    cyc(); #1;
    chk("rd_gnt_back", 32'(id_custom_gnt_o), 32'd1);

    // ---- back-to-back CHECKs, req held, 1-cycle unit latency
    wb_ready_i = 1'b1;
    id_custom_req_i = 1'b1; id_custom_op_i = 5'd2; id_rs1_i = 32'h11; id_rd_addr_i = 5'd1; #1;
    chk("b2b_gnt0", 32'(id_custom_gnt_o), 32'd1);
    cyc(); id_rs1_i = 32'h22; id_rd_addr_i = 5'd2; #1;
    chk("b2b_en1", 32'(ex_custom_en_o), 32'd1);
    chk("b2b_rs1_1", ex_rs1_o, 32'h11);
    chk("b2b_gnt1", 32'(id_custom_gnt_o), 32'd0);
    cyc(); ex_custom_valid_i = 1'b1; ex_custom_result_i = 32'hA1; #1;
    chk("b2b_gnt2", 32'(id_custom_gnt_o), 32'd0);
    cyc(); ex_custom_valid_i = 1'b0; ex_custom_result_i = 32'h0; #1;
    chk("b2b_wbv1", 32'(wb_valid_o), 32'd1);
    chk("b2b_res1", wb_result_o, 32'hA1);
    chk("b2b_rd1", 32'(wb_rd_addr_o), 32'd1);
    chk("b2b_gnt3", 32'(id_custom_gnt_o), 32'd0);
    cyc(); #1;
    chk("b2b_gnt4", 32'(id_custom_gnt_o), 32'd1);
    cyc(); id_custom_req_i = 1'b0; #1;
    chk("b2b_en2", 32'(ex_custom_en_o), 32'd1);
    chk("b2b_rs1_2", ex_rs1_o, 32'h22);
    cyc(); ex_custom_valid_i = 1'b1; ex_custom_result_i = 32'hB2; #1;
    cyc(); ex_custom_valid_i = 1'b0; ex_custom_result_i = 32'h0; #1;
    chk("b2b_wbv2", 32'(wb_valid_o), 32'd1);
    chk("b2b_res2", wb_result_o, 32'hB2);
    chk("b2b_rd2", 32'(wb_rd_addr_o), 32'd2);
    chk("b2b_we2", 32'(wb_we_o), 32'd1);
    cyc(); wb_ready_i = 1'b0; #1;
    chk("b2b_idle", 32'(busy_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ibex_custom_issue.md
Name: ibex_custom_issue

Overview:
- Issue/sequencing stage between the ID stage and the bloom-filter custom unit in the EX block.
- Accepts one decoded custom instruction from ID through a req/gnt handshake and latches its operands.
- Drives a one-cycle enable pulse with stable operands into EX, then waits for the unit's valid, with a timeout.
- Holds the captured result until writeback accepts it; ID is stalled via gnt while an instruction is in flight.

Parameters:
- TimeoutCycles, 64, max cycles spent in WAIT before aborting with error; legal range >= 2.
- OpWidth, 5, width of the custom opcode field.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- id_custom_req_i  in  1  ID presents a custom instruction
- id_custom_gnt_o  out  1  stage accepts the instruction this cycle
- id_custom_op_i  in  OpWidth  custom opcode
- id_rs1_i  in  32  operand RS1
- id_rs2_i  in  32  operand RS2
- id_rd_addr_i  in  5  destination register
- flush_i  in  1  controller kill (exception/branch)
- ex_custom_en_o  out  1  enable pulse to the custom unit
- ex_custom_op_o  out  OpWidth  latched opcode
- ex_rs1_o  out  32  latched RS1
- ex_rs2_o  out  32  latched RS2
- ex_custom_valid_i  in  1  custom unit done
- ex_custom_result_i  in  32  custom unit result
- wb_valid_o  out  1  result available
- wb_ready_i  in  1  writeback accepts
- wb_we_o  out  1  result must be written to rd
- wb_rd_addr_o  out  5  destination register
- wb_result_o  out  32  result data
- wb_err_o  out  1  illegal opcode or timeout
- busy_o  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous and active-high.
- Reset:
  - State returns to IDLE.
  - All outputs are 0, including gnt, on the cycle rst_i is asserted and the first cycle after.
  - Latched op, operands, rd, result and counter are cleared.
  - Reset mid-operation aborts silently; no wb_valid_o is produced.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - id_custom_gnt_o = ~flush_i.
  - On req & gnt, latch op, rs1, rs2 and rd.
  - Legal op goes to ISSUE. An illegal op goes to DONE with err=1 and result=0, and EX is never enabled.
- ISSUE:
  - ex_custom_en_o = 1 for exactly this one cycle; the counter is cleared.
  - If ex_custom_valid_i is asserted in this cycle, capture the result and go to DONE (zero-wait unit). Otherwise go to WAIT.
- WAIT:
  - en = 0; ex_custom_op_o, ex_rs1_o and ex_rs2_o stay stable.
  - On valid, capture ex_custom_result_i and go to DONE.
  - Otherwise increment the counter. When the counter reaches TimeoutCycles-1 without valid, go to DONE with err=1 and result=0.
  - Counter width is $clog2(TimeoutCycles)+1; no wrap is possible.
- DONE:
  - wb_valid_o = 1; rd, result, err and we are stable until wb_ready_i.
  - wb_we_o = (op is CHECK) & ~err.
  - On the valid&ready handshake, go to IDLE. No new grant is given in the DONE cycle, so minimum occupancy is 3 cycles per instruction (IDLE accept, ISSUE, DONE).
- ex_custom_valid_i outside ISSUE/WAIT is ignored; this covers late responses after a timeout or flush.
- flush_i:
  - In any state, the next state is IDLE and wb_valid_o drops the next cycle.
  - Flush wins over a simultaneous req (no accept), over valid, and over the wb handshake (the handshake completes but the state is IDLE either way).
- Ops whose result is unused (RESET, INSERT) still wait for valid, so EX ordering is preserved.

Decomposition:
- ibex_pkg:
  - custom_op_e with CUST_RESET=5'd0, CUST_INSERT=5'd1, CUST_CHECK=5'd2; all other values are illegal.
  - custom_issue_state_e {IDLE, ISSUE, WAIT, DONE}.
  - Helper function custom_op_writes_rd(op).
- No sub-module. The timeout counter is inline; a generic counter is overkill.

Test Plan:
- Legal CHECK: req with op=2, rs1=32'hDEAD_BEEF, rs2=32'h1, rd=5.
  - gnt is high in the same cycle; en pulses once, one cycle later, with ex_rs1_o=DEAD_BEEF.
  - Valid arrives 3 cycles after en with result=1.
  - Expect wb_valid_o=1, we=1, rd=5, result=1, err=0.
  - Holding wb_ready_i=0 for 4 cycles keeps all outputs stable. Ready returns the stage to IDLE, and gnt rises the cycle after.
- INSERT with valid in the ISSUE cycle: op=1.
  - Expect DONE directly after ISSUE, wb_we_o=0, err=0.
  - A stray valid in the following IDLE cycle is ignored.
- Illegal op=5'd7:
  - en is never asserted; DONE follows the cycle after accept with err=1, result=0, we=0.
- Timeout with TimeoutCycles=4 and valid never asserted:
  - Expect DONE with err=1 after 4 WAIT cycles.
  - A late valid with result=32'h55 in IDLE does not change wb_result_o=0.
- Flush and reset:
  - Flush in WAIT: the next cycle is IDLE with busy_o=0 and no wb_valid.
  - Flush with a simultaneous req: gnt=0 and nothing is latched.
  - rst_i pulsed in DONE: all outputs are 0 the next cycle.
- Back-to-back:
  - Two CHECKs with req held high and wb_ready_i=1, each with 1-cycle unit latency.
  - The second grant occurs exactly 4 cycles after the first (IDLE, ISSUE, WAIT, DONE); results are delivered in order.
